// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants.
package riscv_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned PC_STEP     = 4;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue of (pc, instr) entries; flush dominates push and pop.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  wdata,
  output fetch_entry_t  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !flush && (!full || pop);
  assign do_pop  = pop && !flush && !empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; count and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, drives instruction memory, queues words for decode.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = 32'h00000000,
  parameter int unsigned QUEUE_DEPTH   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_rd,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_target,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic [ADDRESS_WIDTH-1:0] out_pc_plus4
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);

  logic [ADDRESS_WIDTH-1:0] pc_q;
  logic [ADDRESS_WIDTH-1:0] pc_d;
  logic                     push_c;
  logic                     pop_c;
  logic                     q_full;
  logic                     q_empty;
  logic [CW-1:0]            q_count;
  fetch_entry_t             q_wdata;
  fetch_entry_t             q_head;

  assign imem_addr = pc_q;
  assign pop_c     = out_valid && out_ready;
  assign push_c    = !redirect_valid && ((q_count < CW'(QUEUE_DEPTH)) || pop_c);

  assign q_wdata.pc    = XLEN'(pc_q);
  assign q_wdata.instr = INSTR_WIDTH'(imem_rd);

  // Redirect wins; targets are forced to word alignment.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_target[ADDRESS_WIDTH-1:2], 2'b00};
    end else if (push_c) begin
      pc_d = pc_q + ADDRESS_WIDTH'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .flush (redirect_valid),
    .wdata (q_wdata),
    .head  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign out_valid    = !q_empty;
  assign out_instr    = DATA_WIDTH'(q_head.instr);
  assign out_pc       = ADDRESS_WIDTH'(q_head.pc);
  assign out_pc_plus4 = out_pc + ADDRESS_WIDTH'(PC_STEP);

  a_full_consistent: assert property (@(posedge clk) disable iff (rst)
    q_full == (q_count == CW'(QUEUE_DEPTH)));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small instruction-memory program.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc, out_pc_plus4;

  logic        rst_w, ready_w;
  logic [31:0] imem_addr_w, imem_rd_w;
  logic        out_valid_w;
  logic [31:0] out_instr_w, out_pc_w, out_pc_plus4_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h00: imem = 32'h0FF00313;
      32'h04: imem = 32'h00000513;
      32'h08: imem = 32'h00000593;
      32'h0C: imem = 32'h00058513;
      32'h10: imem = 32'h00158593;
      32'h14: imem = 32'hFE659CE3;
      32'h18: imem = 32'hFE0318E3;
      default: imem = 32'h00000000;
    endcase
  endfunction

  assign imem_rd   = imem(imem_addr);
  assign imem_rd_w = imem(imem_addr_w);

  fetch_unit u_dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4)
  );

  fetch_unit #(.RESET_PC(32'hFFFFFFF8)) u_wrap (
    .clk(clk), .rst(rst_w), .imem_addr(imem_addr_w), .imem_rd(imem_rd_w),
    .redirect_valid(1'b0), .redirect_target(32'h0),
    .out_valid(out_valid_w), .out_ready(ready_w), .out_instr(out_instr_w),
    .out_pc(out_pc_w), .out_pc_plus4(out_pc_plus4_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_pc"},    out_pc,          pc);
    check({tag, "_instr"}, out_instr,       instr);
    check({tag, "_pc4"},   out_pc_plus4,    pc + 32'd4);
  endtask

  logic [31:0] stream_pc [4]    = '{32'h0, 32'h4, 32'h8, 32'hC};
  logic [31:0] stream_ins [4]   = '{32'h0FF00313, 32'h00000513, 32'h00000593, 32'h00058513};

  initial begin
    rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
    rst_w = 1'b1; ready_w = 1'b1;

    // Reset, then stream with ready high.
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      expect_head($sformatf("stream%0d", i), stream_pc[i], stream_ins[i]);
    end

    // Backpressure fills the queue and freezes the PC.
    rst = 1'b1; out_ready = 1'b0;
    tick;
    check("rst2_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    repeat (5) tick;
    check("full_addr", imem_addr, 32'h8);
    expect_head("hold0", 32'h0, 32'h0FF00313);
    out_ready = 1'b1;
    tick; expect_head("drain4", 32'h4, 32'h00000513);
    tick; expect_head("drain8", 32'h8, 32'h00000593);
    tick; expect_head("drainC", 32'hC, 32'h00058513);
    tick; expect_head("drain10", 32'h10, 32'h00158593);

    // Redirect with queue holding 10,14.
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0C;
    tick;
    check("redir_bubble", 32'(out_valid), 32'd0);
    check("redir_addr", imem_addr, 32'hC);
    redirect_valid = 1'b0;
    tick; expect_head("redirC", 32'hC, 32'h00058513);
    out_ready = 1'b1;
    tick; expect_head("redir10", 32'h10, 32'h00158593);

    // Misaligned redirect coincident with a pop.
    redirect_valid = 1'b1; redirect_target = 32'h0000000E;
    tick;
    check("align_empty", 32'(out_valid), 32'd0);
    check("align_addr", imem_addr, 32'hC);
    redirect_valid = 1'b0;
    tick; expect_head("alignC", 32'hC, 32'h00058513);

    // Reset while the queue is full.
    out_ready = 1'b0;
    tick; tick;
    check("full2_addr", imem_addr, 32'h14);
    check("full2_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick;
    check("rst3_valid", 32'(out_valid), 32'd0);
    check("rst3_addr", imem_addr, 32'h0);
    rst = 1'b0; out_ready = 1'b1;
    tick; expect_head("refetch0", 32'h0, 32'h0FF00313);
    tick; expect_head("refetch4", 32'h4, 32'h00000513);

    // PC wrap-around from a high reset vector.
    rst_w = 1'b0;
    tick;
    check("wrap0_valid", 32'(out_valid_w), 32'd1);
    check("wrap0_pc", out_pc_w, 32'hFFFFFFF8);
    check("wrap0_pc4", out_pc_plus4_w, 32'hFFFFFFFC);
    tick;
    check("wrap1_pc", out_pc_w, 32'hFFFFFFFC);
    check("wrap1_pc4", out_pc_plus4_w, 32'h00000000);
    tick;
    check("wrap2_pc", out_pc_w, 32'h00000000);
    check("wrap2_instr", out_instr_w, 32'h0FF00313);
    check("wrap2_pc4", out_pc_plus4_w, 32'h00000004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
